// File: rtl/display_shuffle_reg.sv
// Keypad symbol table reshuffled by a seeded Fisher-Yates walk driven by a 16-bit Galois LFSR.
// The table is a permutation at all times; data_out is blanked while a shuffle is in flight.
module display_shuffle_reg #(
    parameter int unsigned       NUM_KEYS = 10,
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       IDX_W    = 4,
    parameter logic [DATA_W-1:0] BLANK    = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_init,
    input  logic [31:0]       seed,
    input  logic [IDX_W-1:0]  button_index,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned  CNT_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [15:0]  LFSR_MASK    = 16'hB400;
    localparam logic [15:0]  LFSR_DEFAULT = 16'hACE1;
    localparam logic [CNT_W-1:0] I_START  = CNT_W'(NUM_KEYS - 1);

    typedef enum logic {StIdle, StShuffle} state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [DATA_W-1:0]  r_table [NUM_KEYS];
    logic [15:0]        r_lfsr;
    logic [CNT_W-1:0]   r_i;
    logic               r_done;
    logic [DATA_W-1:0]  r_data;

    logic               w_done_d;
    logic [15:0]        w_lfsr_load;
    logic [15:0]        w_lfsr_next;
    logic [CNT_W-1:0]   w_j;
    logic [CNT_W-1:0]   w_sel;
    logic               w_idx_ok;
    logic [DATA_W-1:0]  w_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        if (shuffle_init) begin
            w_state_d = StShuffle;
        end else if (r_state == StShuffle && r_i == CNT_W'(1)) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
        end
    end

    always_comb begin
        w_lfsr_load = seed[15:0] ^ seed[31:16];
        // An all-zero Galois LFSR would lock up, so substitute a fixed nonzero start.
        if (w_lfsr_load == 16'h0000) begin
            w_lfsr_load = LFSR_DEFAULT;
        end
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        w_j         = CNT_W'(r_lfsr % (16'(r_i) + 16'd1));
        w_sel       = CNT_W'(button_index);
        w_idx_ok    = 32'(button_index) < NUM_KEYS;
        w_data_d    = BLANK;
        if (w_idx_ok && r_state == StIdle && !shuffle_init) begin
            w_data_d = r_table[w_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                r_table[k] <= DATA_W'(k);
            end
            r_lfsr <= LFSR_DEFAULT;
            r_i    <= '0;
            r_done <= 1'b0;
            r_data <= '0;
        end else begin
            r_done <= w_done_d;
            r_data <= w_data_d;
            if (shuffle_init) begin
                for (int k = 0; k < int'(NUM_KEYS); k++) begin
                    r_table[k] <= DATA_W'(k);
                end
                r_lfsr <= w_lfsr_load;
                r_i    <= I_START;
            end else if (r_state == StShuffle) begin
                // When j == i both writes carry the same value, so the entry is unchanged.
                r_table[r_i] <= r_table[w_j];
                r_table[w_j] <= r_table[r_i];
                r_i          <= r_i - CNT_W'(1);
                r_lfsr       <= w_lfsr_next;
            end
        end
    end

    assign data_out = r_data;
    assign busy     = (r_state == StShuffle);
    assign done     = r_done;

endmodule

// File: tb/tb_display_shuffle_reg.sv
// Scoreboarded directed bench for display_shuffle_reg at NUM_KEYS = 10, 2 and 16.
// Expected tables come from an independent Fisher-Yates / Galois LFSR model.
module tb_display_shuffle_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        si;
    logic [31:0] seed;
    logic [3:0]  bi;
    logic [3:0]  do_a, do_b, do_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;
    int busy_cnt_a = 0, busy_cnt_b = 0, busy_cnt_c = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
    int base_busy_a, base_busy_b, base_busy_c;
    int base_done_a, base_done_b, base_done_c;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] qc[$];

    always #5 clk = ~clk;

    display_shuffle_reg #(.NUM_KEYS(10)) u_a (
        .clk(clk), .rst(rst), .shuffle_init(si), .seed(seed), .button_index(bi),
        .data_out(do_a), .busy(busy_a), .done(done_a)
    );
    display_shuffle_reg #(.NUM_KEYS(2)) u_b (
        .clk(clk), .rst(rst), .shuffle_init(si), .seed(seed), .button_index(bi),
        .data_out(do_b), .busy(busy_b), .done(done_b)
    );
    display_shuffle_reg #(.NUM_KEYS(16)) u_c (
        .clk(clk), .rst(rst), .shuffle_init(si), .seed(seed), .button_index(bi),
        .data_out(do_c), .busy(busy_c), .done(done_c)
    );

    always @(negedge clk) begin
        if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
        if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
        if (busy_c) busy_cnt_c <= busy_cnt_c + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
    end

    function automatic logic [63:0] ref_tab(input int n, input logic [31:0] sd);
        logic [15:0] l;
        logic [63:0] t;
        logic [3:0]  tmp;
        int          j;
        l = sd[15:0] ^ sd[31:16];
        if (l == 16'h0000) l = 16'hACE1;
        for (int k = 0; k < 16; k++) t[k*4 +: 4] = 4'(k);
        for (int i = n - 1; i >= 1; i--) begin
            j = int'(l % 16'(i + 1));
            tmp = t[i*4 +: 4];
            t[i*4 +: 4] = t[j*4 +: 4];
            t[j*4 +: 4] = tmp;
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tc,
                         input string tag);
        logic [15:0] sa;
        logic [15:0] sb;
        logic [15:0] sc;
        sa = '0;
        sb = '0;
        sc = '0;
        for (int k = 0; k < 16; k++) begin
            bi = 4'(k);
            qa.push_back(k < 10 ? ta[k*4 +: 4] : 4'hF);
            qb.push_back(k < 2 ? tb[k*4 +: 4] : 4'hF);
            qc.push_back(tc[k*4 +: 4]);
            tick();
            chk($sformatf("%s_a[%0d]", tag, k), 32'(do_a), 32'(qa.pop_front()));
            chk($sformatf("%s_b[%0d]", tag, k), 32'(do_b), 32'(qb.pop_front()));
            chk($sformatf("%s_c[%0d]", tag, k), 32'(do_c), 32'(qc.pop_front()));
            if (k < 10 && !$isunknown(do_a)) sa[do_a] = 1'b1;
            if (k < 2 && !$isunknown(do_b)) sb[do_b] = 1'b1;
            if (!$isunknown(do_c)) sc[do_c] = 1'b1;
        end
        chk({tag, "_perm_a"}, 32'(sa), 32'h03FF);
        chk({tag, "_perm_b"}, 32'(sb), 32'h0003);
        chk({tag, "_perm_c"}, 32'(sc), 32'hFFFF);
    endtask

    task automatic snap();
        base_busy_a = busy_cnt_a; base_busy_b = busy_cnt_b; base_busy_c = busy_cnt_c;
        base_done_a = done_cnt_a; base_done_b = done_cnt_b; base_done_c = done_cnt_c;
    endtask

    initial begin
        rst  = 1'b0;
        si   = 1'b0;
        seed = '0;
        bi   = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_dout_a", 32'(do_a), 32'd0);
        chk("rst_dout_c", 32'(do_c), 32'd0);
        tick();
        rst = 1'b0;

        // Idle queries, valid and out of range.
        bi = 4'd3;  qa.push_back(4'd3); tick();
        chk("idle_idx3", 32'(do_a), 32'(qa.pop_front()));
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_done", 32'(done_a), 32'd0);
        bi = 4'd12; qa.push_back(4'hF); tick();
        chk("idle_idx12", 32'(do_a), 32'(qa.pop_front()));
        bi = 4'd15; qa.push_back(4'hF); tick();
        chk("idle_idx15", 32'(do_a), 32'(qa.pop_front()));

        // Seed 0 falls back to 16'hACE1.
        snap();
        si = 1'b1; seed = 32'h0; bi = 4'd3; tick(); si = 1'b0;
        chk("busy_rise", 32'(busy_a), 32'd1);
        tick(); tick();
        chk("busy_blank_idx3", 32'(do_a), 32'hF);
        bi = 4'd12; tick();
        chk("busy_blank_idx12", 32'(do_a), 32'hF);
        bi = 4'd15; tick();
        chk("busy_blank_idx15", 32'(do_a), 32'hF);
        repeat (20) tick();
        chk("seed0_busy_len_a", 32'(busy_cnt_a - base_busy_a), 32'd9);
        chk("seed0_busy_len_b", 32'(busy_cnt_b - base_busy_b), 32'd1);
        chk("seed0_busy_len_c", 32'(busy_cnt_c - base_busy_c), 32'd15);
        chk("seed0_done_a", 32'(done_cnt_a - base_done_a), 32'd1);
        chk("seed0_done_b", 32'(done_cnt_b - base_done_b), 32'd1);
        chk("seed0_done_c", 32'(done_cnt_c - base_done_c), 32'd1);
        sweep(ref_tab(10, 32'h0), ref_tab(2, 32'h0), ref_tab(16, 32'h0), "seed0");

        // Restart on busy cycle 4 with a different seed.
        snap();
        si = 1'b1; seed = 32'h1234_5678; tick(); si = 1'b0;
        tick(); tick(); tick();
        si = 1'b1; seed = 32'hCAFE_0042; tick(); si = 1'b0;
        base_busy_a = busy_cnt_a; base_busy_c = busy_cnt_c;
        repeat (20) tick();
        chk("restart_busy_len_a", 32'(busy_cnt_a - base_busy_a), 32'd9);
        chk("restart_busy_len_c", 32'(busy_cnt_c - base_busy_c), 32'd15);
        chk("restart_done_a", 32'(done_cnt_a - base_done_a), 32'd1);
        chk("restart_done_c", 32'(done_cnt_c - base_done_c), 32'd1);
        sweep(ref_tab(10, 32'hCAFE_0042), ref_tab(2, 32'hCAFE_0042),
              ref_tab(16, 32'hCAFE_0042), "restart");

        // Reset on busy cycle 5 aborts without done.
        snap();
        si = 1'b1; seed = 32'h0BAD_F00D; tick(); si = 1'b0;
        repeat (4) tick();
        chk("midrst_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_dout", 32'(do_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("midrst_no_done_a", 32'(done_cnt_a - base_done_a), 32'd0);
        chk("midrst_no_done_c", 32'(done_cnt_c - base_done_c), 32'd0);
        sweep(ref_tab(1, 32'h0), ref_tab(1, 32'h0), ref_tab(1, 32'h0), "midrst_ident");

        // Determinism: the same seed twice.
        for (int r = 0; r < 2; r++) begin
            snap();
            si = 1'b1; seed = 32'h0001_0003; tick(); si = 1'b0;
            repeat (20) tick();
            chk($sformatf("det%0d_done_a", r), 32'(done_cnt_a - base_done_a), 32'd1);
            sweep(ref_tab(10, 32'h0001_0003), ref_tab(2, 32'h0001_0003),
                  ref_tab(16, 32'h0001_0003), $sformatf("det%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_shuffle_reg.md
DISPLAY_SHUFFLE_REG -- requirements
Module: display_shuffle_reg

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 10, meaning the number of keypad positions and symbols; the legal range is 2..16.
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning the symbol width; it SHALL be >= clog2(NUM_KEYS).
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning the button index width; it SHALL be >= clog2(NUM_KEYS).
REQ-004 The block SHALL have parameter BLANK, default all-ones of DATA_W, meaning the symbol output when no valid symbol is available.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port shuffle_init, input, 1 bit: request a new shuffle, sampled on clk.
REQ-008 The block SHALL have port seed, input, 32 bits: randomisation seed, typically the free-running clk_count, sampled together with shuffle_init.
REQ-009 The block SHALL have port button_index, input, IDX_W bits: the keypad position being queried.
REQ-010 The block SHALL have port data_out, output, DATA_W bits: the symbol at button_index (registered).
REQ-011 The block SHALL have port busy, output, 1 bit: high while a shuffle is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a single-cycle pulse when a shuffle completes.

Function
REQ-013 The block SHALL hold a table of NUM_KEYS entries, each DATA_W bits; the table SHALL always be a permutation of 0..NUM_KEYS-1.
REQ-014 The FSM SHALL have states IDLE and SHUFFLE; it SHALL leave IDLE only on shuffle_init=1.
REQ-015 At an edge in either state with shuffle_init=1, the block SHALL:
- reset the table to identity (entry k = k);
- load the LFSR;
- set counter i = NUM_KEYS-1;
- enter SHUFFLE with busy=1 from the next cycle.
REQ-016 The LFSR SHALL be a 16-bit Galois LFSR with polynomial mask 16'hB400, shifting right each SHUFFLE cycle.
REQ-017 The LFSR load value SHALL be seed[15:0] XOR seed[31:16]; if that value is 0, the block SHALL load 16'hACE1 instead.
REQ-018 On each SHUFFLE edge (with shuffle_init=0), the block SHALL:
- compute j = lfsr mod (i+1);
- swap table[i] with table[j] (no change when j = i);
- decrement i;
- advance the LFSR.
REQ-019 The swap that uses i=1 SHALL be the last swap; on that edge the FSM SHALL return to IDLE, busy SHALL fall, and done SHALL be 1 for exactly the following cycle.
REQ-020 busy SHALL be high for exactly NUM_KEYS-1 consecutive cycles per uninterrupted shuffle.
REQ-021 shuffle_init=1 during SHUFFLE SHALL restart the shuffle per REQ-015, with no done pulse for the aborted shuffle.
REQ-022 data_out SHALL be registered: the value after edge t SHALL reflect button_index and the table as sampled at edge t.
REQ-023 data_out SHALL be BLANK when button_index >= NUM_KEYS.
REQ-024 data_out SHALL be BLANK while busy is high, or when the shuffle is restarting on the same edge.
REQ-025 Otherwise data_out SHALL be table[button_index].
REQ-026 The block SHALL be deterministic: the same seed and the same cycle of shuffle_init SHALL always yield the same table.

Reset
REQ-027 When rst=1, the block SHALL immediately, without waiting for clk:
- set the table to identity;
- set the FSM to IDLE;
- set busy=0, done=0, data_out=0;
- set the LFSR to 16'hACE1;
- set i=0.
REQ-028 Reset asserted mid-shuffle SHALL abort the shuffle with no done pulse.
REQ-029 After rst deasserts, the first edge SHALL behave as in IDLE.

Verification
REQ-030 Reset, then button_index=3 with no shuffle -> data_out=3 one cycle later; busy=0, done=0.
REQ-031 seed=0, one-cycle shuffle_init pulse -> LFSR loads 16'hACE1; busy high for exactly 9 cycles; done one-cycle pulse; sweeping indices 0..9 yields each of 0..9 exactly once, matching a reference model of REQ-016..REQ-018.
REQ-032 Query button_index=12 and 15 in IDLE and while busy -> data_out=4'hF (BLANK) in both cases.
REQ-033 shuffle_init re-pulsed on busy cycle 4 with a new seed -> busy extends to 9 cycles from the restart; exactly one done pulse; the table equals a fresh shuffle with the new seed.
REQ-034 rst pulsed on busy cycle 5 -> busy=0 and data_out=0 immediately; no done pulse; identity table afterwards.
REQ-035 Two shuffles with seed=32'h0001_0003 -> identical tables; parameter sweep NUM_KEYS=2 (busy 1 cycle) and NUM_KEYS=16 (busy 15 cycles), with the permutation property holding in both.
